// File: rtl/tod_timer.sv
// Time-of-day timer: seconds/nanoseconds clock with fractional rate trim, absolute
// load, signed offset step, per-channel timestamp capture, 1PPS and legacy ns counter.
module tod_timer #(
   parameter int unsigned SEC_W  = 48,
   parameter int unsigned INC_NS = 4,
   parameter int unsigned FRAC_W = 16,
   parameter int unsigned N_CAP  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [8+FRAC_W-1:0]      inc_cfg,
   input  logic                     inc_wr,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [SEC_W-1:0]         load_sec,
   input  logic [29:0]              load_ns,
   output logic                     load_err,
   input  logic                     adj_valid,
   output logic                     adj_ready,
   input  logic [30:0]              adj_ns,
   input  logic [N_CAP-1:0]         cap_req,
   output logic [N_CAP-1:0]         cap_valid,
   output logic [N_CAP*SEC_W-1:0]   cap_sec,
   output logic [N_CAP*30-1:0]      cap_ns,
   output logic [SEC_W-1:0]         tod_sec,
   output logic [29:0]              tod_ns,
   output logic                     pps,
   output logic [31:0]              counter_ns
);

   localparam int unsigned NS_W   = 30;
   localparam int unsigned INC_W  = 8 + FRAC_W;
   localparam int unsigned STEP_W = 9;
   localparam logic [NS_W-1:0]   NS_LIMIT   = NS_W'(1_000_000_000);
   localparam logic signed [31:0] NS_PER_SEC = 32'sd1_000_000_000;

   typedef enum logic {IDLE, APPLY} state_t;

   typedef struct packed {
      logic             is_load;
      logic [SEC_W-1:0] sec;
      logic [NS_W-1:0]  ns;
      logic [30:0]      adj;
   } req_t;

   state_t state, state_nx;
   req_t   req_q, req_nx;

   logic [INC_W-1:0]    inc;
   logic [FRAC_W-1:0]   frac_acc, frac_nx;
   logic                carry;
   logic [STEP_W-1:0]   step;
   logic [N_CAP-1:0]    req_d, cap_edge;

   logic                ready_nx, err_nx, pps_nx;
   logic [SEC_W-1:0]    sec_nx;
   logic [NS_W-1:0]     ns_nx;
   logic signed [31:0]  adj_term, ns_sum;

   // Fractional accumulator; its carry adds one extra ns to this cycle's step
   assign {carry, frac_nx} = (FRAC_W+1)'(frac_acc) + (FRAC_W+1)'(inc[FRAC_W-1:0]);
   assign step     = STEP_W'(inc[INC_W-1:FRAC_W]) + STEP_W'(carry);
   assign cap_edge = cap_req & ~req_d;
   assign adj_ready = load_ready;

   // Next-state, request arbitration and time update
   always_comb begin
      state_nx = state;
      req_nx   = req_q;
      err_nx   = 1'b0;
      pps_nx   = 1'b0;
      sec_nx   = tod_sec;
      ns_nx    = tod_ns;
      adj_term = (state == APPLY && !req_q.is_load) ? {req_q.adj[30], req_q.adj} : 32'sd0;
      ns_sum   = $signed({2'b00, tod_ns}) + $signed({23'd0, step}) + adj_term;

      if (state == APPLY && req_q.is_load && req_q.ns < NS_LIMIT) begin
         sec_nx = req_q.sec;
         ns_nx  = req_q.ns;
      end else if (ns_sum >= NS_PER_SEC) begin
         ns_nx  = NS_W'(ns_sum - NS_PER_SEC);
         sec_nx = tod_sec + SEC_W'(1);
         pps_nx = 1'b1;
      end else if (ns_sum < 32'sd0) begin
         ns_nx  = NS_W'(ns_sum + NS_PER_SEC);
         sec_nx = tod_sec - SEC_W'(1);
      end else begin
         ns_nx  = NS_W'(ns_sum);
      end

      case (state)
         IDLE: begin
            // Load has priority; a simultaneous adjust stays pending
            if (load_valid) begin
               req_nx.is_load = 1'b1;
               req_nx.sec     = load_sec;
               req_nx.ns      = load_ns;
               err_nx         = (load_ns >= NS_LIMIT);
               state_nx       = APPLY;
            end else if (adj_valid) begin
               req_nx.is_load = 1'b0;
               req_nx.adj     = adj_ns;
               state_nx       = APPLY;
            end
         end
         APPLY:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      ready_nx = (state_nx == IDLE);
   end

   // State and time registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_q      <= '0;
         inc        <= {8'(INC_NS), FRAC_W'(0)};
         frac_acc   <= '0;
         tod_sec    <= '0;
         tod_ns     <= '0;
         counter_ns <= '0;
         pps        <= 1'b0;
         load_err   <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_nx;
         req_q      <= req_nx;
         frac_acc   <= frac_nx;
         tod_sec    <= sec_nx;
         tod_ns     <= ns_nx;
         counter_ns <= counter_ns + 32'(step);
         pps        <= pps_nx;
         load_err   <= err_nx;
         load_ready <= ready_nx;
         if (inc_wr) inc <= inc_cfg;
      end
   end

   // Timestamp capture on the rising edge of each request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_d     <= '0;
         cap_valid <= '0;
         cap_sec   <= '0;
         cap_ns    <= '0;
      end else begin
         req_d     <= cap_req;
         cap_valid <= cap_edge;
         for (int i = 0; i < int'(N_CAP); i++) begin
            if (cap_edge[i]) begin
               cap_sec[i*SEC_W +: SEC_W] <= tod_sec;
               cap_ns[i*NS_W +: NS_W]    <= tod_ns;
            end
         end
      end
   end

endmodule

// File: tb/tb_tod_timer.sv
// Bench for tod_timer: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model that keeps time as plain integer seconds/ns.
module tb_tod_timer;

   localparam int unsigned SEC_W  = 48;
   localparam int unsigned FRAC_W = 16;
   localparam int unsigned N_CAP  = 2;
   localparam longint NS1     = 1_000_000_000;
   localparam longint SEC_MOD = longint'(1) << 48;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [8+FRAC_W-1:0]    inc_cfg = '0;
   logic                   inc_wr = 1'b0;
   logic                   load_valid = 1'b0;
   logic                   load_ready;
   logic [SEC_W-1:0]       load_sec = '0;
   logic [29:0]            load_ns = '0;
   logic                   load_err;
   logic                   adj_valid = 1'b0;
   logic                   adj_ready;
   logic [30:0]            adj_ns = '0;
   logic [N_CAP-1:0]       cap_req = '0;
   logic [N_CAP-1:0]       cap_valid;
   logic [N_CAP*SEC_W-1:0] cap_sec;
   logic [N_CAP*30-1:0]    cap_ns;
   logic [SEC_W-1:0]       tod_sec;
   logic [29:0]            tod_ns;
   logic                   pps;
   logic [31:0]            counter_ns;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tod_timer #(.SEC_W(SEC_W), .INC_NS(4), .FRAC_W(FRAC_W), .N_CAP(N_CAP)) dut (
      .clk(clk), .rst_n(rst_n), .inc_cfg(inc_cfg), .inc_wr(inc_wr),
      .load_valid(load_valid), .load_ready(load_ready), .load_sec(load_sec),
      .load_ns(load_ns), .load_err(load_err), .adj_valid(adj_valid),
      .adj_ready(adj_ready), .adj_ns(adj_ns), .cap_req(cap_req),
      .cap_valid(cap_valid), .cap_sec(cap_sec), .cap_ns(cap_ns),
      .tod_sec(tod_sec), .tod_ns(tod_ns), .pps(pps), .counter_ns(counter_ns)
   );

   // Reference model: integer time arithmetic with floor-divide normalisation
   longint m_sec, m_ns, m_cnt, m_lsec, m_lns, m_adj, m_step, m_n, m_ds;
   longint m_frac, m_inc;
   bit     m_pps, m_err, m_ready, m_busy, m_is_load;
   logic [N_CAP-1:0] m_capv, m_req_d;
   longint m_csec [N_CAP];
   longint m_cns  [N_CAP];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sec = 0; m_ns = 0; m_cnt = 0; m_frac = 0; m_inc = 4 * 65536;
         m_pps = 0; m_err = 0; m_ready = 1; m_busy = 0; m_is_load = 0;
         m_capv = '0; m_req_d = '0;
         for (int i = 0; i < N_CAP; i++) begin m_csec[i] = 0; m_cns[i] = 0; end
      end else begin
         m_step = (m_inc / 65536) + ((m_frac + (m_inc % 65536)) / 65536);
         m_frac = (m_frac + (m_inc % 65536)) % 65536;
         m_cnt  = (m_cnt + m_step) % (longint'(1) << 32);
         for (int i = 0; i < N_CAP; i++) begin
            m_capv[i] = cap_req[i] & ~m_req_d[i];
            if (m_capv[i]) begin m_csec[i] = m_sec; m_cns[i] = m_ns; end
         end
         m_req_d = cap_req;
         m_pps = 0;
         if (m_busy && m_is_load && m_lns < NS1) begin
            m_sec = m_lsec; m_ns = m_lns;
         end else begin
            m_n  = m_ns + m_step + ((m_busy && !m_is_load) ? m_adj : 0);
            m_ds = (m_n < 0) ? -1 : m_n / NS1;
            m_ns = m_n - m_ds * NS1;
            m_sec = (m_sec + m_ds + SEC_MOD) % SEC_MOD;
            m_pps = (m_ds > 0);
         end
         m_err = 0;
         if (m_busy) begin
            m_busy = 0; m_ready = 1;
         end else if (load_valid) begin
            m_busy = 1; m_ready = 0; m_is_load = 1;
            m_lsec = longint'(load_sec); m_lns = longint'(load_ns);
            m_err = (m_lns >= NS1);
         end else if (adj_valid) begin
            m_busy = 1; m_ready = 0; m_is_load = 0;
            m_adj = longint'($signed(adj_ns));
         end
         if (inc_wr) m_inc = longint'(inc_cfg);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_load(input logic [47:0] s, input logic [29:0] n);
      load_valid = 1'b1; load_sec = s; load_ns = n;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({tod_sec, tod_ns, counter_ns, pps, load_err, cap_valid, cap_sec, cap_ns, load_ready, adj_ready}
          !== {48'd0, 30'd0, 32'd0, 1'b0, 1'b0, 2'b00, 96'd0, 60'd0, 2'b11}) begin
         n_bad++;
         $display("FAIL reset_state: sec=%0d ns=%0d cnt=%0d pps=%b err=%b capv=%b rdy=%b/%b required zeros with ready=1",
                  tod_sec, tod_ns, counter_ns, pps, load_err, cap_valid, load_ready, adj_ready);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_cmp++;
         if (pps !== 1'b0) begin n_bad++; $display("FAIL run10_pps: got %b at cycle %0d required 0", pps, c); end
      end
      n_cmp++;
      if ({tod_sec, tod_ns, counter_ns} !== {48'd0, 30'd40, 32'd40}) begin
         n_bad++;
         $display("FAIL run10_time: got %0d/%0d cnt=%0d required 0/40 cnt=40", tod_sec, tod_ns, counter_ns);
      end
   endtask

   task automatic test_load();
      drive_load(48'd5, 30'd999_999_996);
      n_cmp++;
      if ({load_ready, adj_ready, load_err} !== 3'b000) begin
         n_bad++; $display("FAIL load_apply_ready: got rdy=%b/%b err=%b required 0/0 err=0", load_ready, adj_ready, load_err);
      end
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps, load_ready} !== {48'd5, 30'd999_999_996, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL load_value: got %0d/%0d pps=%b rdy=%b required 5/999999996 pps=0 rdy=1", tod_sec, tod_ns, pps, load_ready);
      end
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps} !== {48'd6, 30'd0, 1'b1}) begin
         n_bad++; $display("FAIL load_rollover: got %0d/%0d pps=%b required 6/0 pps=1", tod_sec, tod_ns, pps);
      end
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps} !== {48'd6, 30'd4, 1'b0}) begin
         n_bad++; $display("FAIL load_after_pps: got %0d/%0d pps=%b required 6/4 pps=0", tod_sec, tod_ns, pps);
      end
      // Seconds field wraps to zero
      drive_load(48'hFFFF_FFFF_FFFF, 30'd999_999_996);
      tick();
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps} !== {48'd0, 30'd0, 1'b1}) begin
         n_bad++; $display("FAIL sec_wrap: got %0d/%0d pps=%b required 0/0 pps=1", tod_sec, tod_ns, pps);
      end
   endtask

   task automatic test_inc();
      int     exp_ns [4] = '{4, 9, 13, 18};
      longint base;
      drive_load(48'd7, 30'd0);
      inc_wr = 1'b1; inc_cfg = 24'h048000;
      tick();
      inc_wr = 1'b0;
      base = m_cnt;
      n_cmp++;
      if (tod_ns !== 30'd0) begin n_bad++; $display("FAIL inc_start: got %0d required 0", tod_ns); end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (tod_ns !== 30'(exp_ns[k])) begin
            n_bad++; $display("FAIL inc_frac_step%0d: got %0d required %0d", k, tod_ns, exp_ns[k]);
         end
      end
      n_cmp++;
      if (counter_ns !== 32'(base + 18)) begin
         n_bad++; $display("FAIL inc_counter: got %0d required %0d", counter_ns, base + 18);
      end
      inc_wr = 1'b1; inc_cfg = 24'h040000;
      tick();
      inc_wr = 1'b0;
   endtask

   task automatic test_adjust();
      drive_load(48'd1, 30'd36);
      tick();
      adj_valid = 1'b1; adj_ns = 31'(-100);
      tick();
      adj_valid = 1'b0;
      n_cmp++;
      if ({tod_sec, tod_ns, adj_ready} !== {48'd1, 30'd40, 1'b0}) begin
         n_bad++; $display("FAIL adj_neg_apply: got %0d/%0d rdy=%b required 1/40 rdy=0", tod_sec, tod_ns, adj_ready);
      end
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps} !== {48'd0, 30'd999_999_944, 1'b0}) begin
         n_bad++; $display("FAIL adj_neg: got %0d/%0d pps=%b required 0/999999944 pps=0", tod_sec, tod_ns, pps);
      end
      drive_load(48'd0, 30'd999_999_896);
      tick();
      adj_valid = 1'b1; adj_ns = 31'd200;
      tick();
      adj_valid = 1'b0;
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, pps} !== {48'd1, 30'd104, 1'b1}) begin
         n_bad++; $display("FAIL adj_pos: got %0d/%0d pps=%b required 1/104 pps=1", tod_sec, tod_ns, pps);
      end
   endtask

   task automatic test_capture();
      int     pulses = 0;
      longint es, en;
      drive_load(48'd0, 30'd992);
      tick(); tick(); tick();
      cap_req = 2'b10;
      tick();
      cap_req = 2'b00;
      n_cmp++;
      if ({cap_valid, cap_sec[SEC_W +: SEC_W], cap_ns[30 +: 30]} !== {2'b10, 48'd0, 30'd1000}) begin
         n_bad++; $display("FAIL cap_ch1: got capv=%b %0d/%0d required capv=10 0/1000",
                           cap_valid, cap_sec[SEC_W +: SEC_W], cap_ns[30 +: 30]);
      end
      tick();
      n_cmp++;
      if (cap_valid !== 2'b00) begin n_bad++; $display("FAIL cap_pulse_len: got %b required 00", cap_valid); end
      cap_req = 2'b01;
      for (int c = 0; c < 5; c++) begin tick(); pulses += int'(cap_valid[0]); end
      cap_req = 2'b00;
      for (int c = 0; c < 2; c++) begin tick(); pulses += int'(cap_valid[0]); end
      n_cmp++;
      if (pulses != 1) begin n_bad++; $display("FAIL cap_held: got %0d pulses required 1", pulses); end
      es = m_sec; en = m_ns;
      cap_req = 2'b11;
      tick();
      cap_req = 2'b00;
      n_cmp++;
      if ({cap_valid, cap_sec, cap_ns} !== {2'b11, 48'(es), 48'(es), 30'(en), 30'(en)}) begin
         n_bad++; $display("FAIL cap_both: got capv=%b sec=%h ns=%h required 11 %0d/%0d", cap_valid, cap_sec, cap_ns, es, en);
      end
   endtask

   task automatic test_load_err();
      longint es, en;
      es = m_sec; en = m_ns;
      drive_load(48'd77, 30'd1_000_000_000);
      n_cmp++;
      if (load_err !== 1'b1) begin n_bad++; $display("FAIL load_err_pulse: got %b required 1", load_err); end
      tick();
      n_cmp++;
      if ({load_err, tod_sec, tod_ns} !== {1'b0, 48'(es), 30'(en + 8)}) begin
         n_bad++; $display("FAIL load_err_tod: got err=%b %0d/%0d required err=0 %0d/%0d", load_err, tod_sec, tod_ns, es, en + 8);
      end
   endtask

   task automatic test_back_to_back();
      load_valid = 1'b1; load_sec = 48'd3; load_ns = 30'd5000;
      adj_valid = 1'b1; adj_ns = 31'd1000;
      tick();
      load_valid = 1'b0;
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns, load_ready} !== {48'd3, 30'd5000, 1'b1}) begin
         n_bad++; $display("FAIL b2b_load_wins: got %0d/%0d rdy=%b required 3/5000 rdy=1", tod_sec, tod_ns, load_ready);
      end
      tick();
      adj_valid = 1'b0;
      n_cmp++;
      if (adj_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_adj_accept: got rdy=%b required 0", adj_ready); end
      tick();
      n_cmp++;
      if ({tod_sec, tod_ns} !== {48'd3, 30'd6008}) begin
         n_bad++; $display("FAIL b2b_adj: got %0d/%0d required 3/6008", tod_sec, tod_ns);
      end
   endtask

   task automatic test_random();
      int unsigned mag;
      logic [N_CAP*SEC_W-1:0] e_cs;
      logic [N_CAP*30-1:0]    e_cn;
      for (int c = 0; c < 3000; c++) begin
         inc_wr = ($urandom_range(63, 0) == 0);
         inc_cfg = {8'($urandom_range(12, 0)), 16'($urandom)};
         load_valid = ($urandom_range(15, 0) == 0);
         load_sec = 48'({$urandom, $urandom});
         load_ns = ($urandom_range(7, 0) == 0) ? 30'($urandom_range(1073741823, 999_999_990))
                                                : 30'($urandom_range(999_999_999, 0));
         adj_valid = ($urandom_range(7, 0) == 0);
         mag = $urandom_range(999_999_999, 0);
         adj_ns = $urandom_range(1, 0) ? 31'(-int'(mag)) : 31'(mag);
         cap_req = N_CAP'($urandom);
         tick();
         for (int i = 0; i < N_CAP; i++) begin
            e_cs[i*SEC_W +: SEC_W] = SEC_W'(m_csec[i]);
            e_cn[i*30 +: 30] = 30'(m_cns[i]);
         end
         n_cmp++;
         if ({tod_sec, tod_ns, pps} !== {SEC_W'(m_sec), 30'(m_ns), m_pps}) begin
            n_bad++; $display("FAIL rnd_tod c%0d: got %0d/%0d pps=%b required %0d/%0d pps=%b",
                              c, tod_sec, tod_ns, pps, m_sec, m_ns, m_pps);
         end
         n_cmp++;
         if (counter_ns !== 32'(m_cnt)) begin
            n_bad++; $display("FAIL rnd_counter c%0d: got %0d required %0d", c, counter_ns, m_cnt);
         end
         n_cmp++;
         if ({load_ready, adj_ready, load_err} !== {m_ready, m_ready, m_err}) begin
            n_bad++; $display("FAIL rnd_hs c%0d: got rdy=%b/%b err=%b required %b err=%b",
                              c, load_ready, adj_ready, load_err, m_ready, m_err);
         end
         n_cmp++;
         if ({cap_valid, cap_sec, cap_ns} !== {m_capv, e_cs, e_cn}) begin
            n_bad++; $display("FAIL rnd_cap c%0d: got v=%b %h %h required v=%b %h %h",
                              c, cap_valid, cap_sec, cap_ns, m_capv, e_cs, e_cn);
         end
      end
      inc_wr = 1'b0; load_valid = 1'b0; adj_valid = 1'b0; cap_req = '0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      drive_load(48'd9, 30'd123);
      n_cmp++;
      if (load_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_apply: got rdy=%b required 0", load_ready); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({tod_sec, tod_ns, counter_ns, pps, load_err, cap_valid, cap_sec, cap_ns, load_ready, adj_ready}
          !== {48'd0, 30'd0, 32'd0, 1'b0, 1'b0, 2'b00, 96'd0, 60'd0, 2'b11}) begin
         n_bad++; $display("FAIL rstmid_state: got %0d/%0d cnt=%0d capv=%b rdy=%b required zeros rdy=1",
                           tod_sec, tod_ns, counter_ns, cap_valid, load_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      n_cmp++;
      if ({tod_sec, tod_ns, counter_ns, load_ready} !== {48'd0, 30'd8, 32'd8, 1'b1}) begin
         n_bad++; $display("FAIL rstmid_discard: got %0d/%0d cnt=%0d rdy=%b required 0/8 cnt=8 rdy=1",
                           tod_sec, tod_ns, counter_ns, load_ready);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_load();
      test_inc();
      test_adjust();
      test_capture();
      test_load_err();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
